// File: rtl/ibex_csr_rmw_arb_if.sv
// Bus bundle for the CSR read-modify-write arbiter: two requester ports, one response port
// and the connection to the CSR storage primitive.
interface ibex_csr_rmw_arb_if #(
    parameter int unsigned Width = 32
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][1:0]       req_op;
    logic [1:0][Width-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_id;
    logic [Width-1:0]      rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_ready;

    logic [Width-1:0]      csr_wr_data;
    logic                  csr_wr_en;
    logic [Width-1:0]      csr_rd_data;
    logic                  csr_rd_error;

    modport slave (
        input  req_valid, req_op, req_wdata, rsp_ready, csr_rd_data, csr_rd_error,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_error, csr_wr_data, csr_wr_en
    );

    modport master (
        output req_valid, req_op, req_wdata, rsp_ready, csr_rd_data, csr_rd_error,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_error, csr_wr_data, csr_wr_en
    );
endinterface

// File: rtl/ibex_csr_rmw_arb.sv
// Round-robin arbiter between the core CSR path and the debug/DMA path, running each
// READ/WRITE/SET/CLEAR as one atomic read-then-write on a shared CSR primitive.
//
// state | meaning
// IDLE  | arbitrate; grant one requester and latch its op/operand
// EXEC  | read CSR, compute masked result, write unless read-integrity error
// RESP  | hold response until consumer accepts
module ibex_csr_rmw_arb #(
    parameter int unsigned      Width     = 32,
    parameter logic [Width-1:0] WriteMask = '1,
    parameter int unsigned      ResetPrio = 0
) (
    input logic                clk,
    input logic                rst_n,
    ibex_csr_rmw_arb_if.slave  bus
);

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q;
    logic             id_q;
    logic [1:0]       op_q;
    logic [Width-1:0] wdata_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [Width-1:0] rsp_rdata_q;
    logic             rsp_error_q;

    logic             any_valid;
    logic             gnt_id;
    logic             req_hs;
    logic [Width-1:0] old_val;
    logic [Width-1:0] new_val;
    logic [Width-1:0] wr_val;

    // With both requesters valid the pointer decides; a lone requester always wins.
    assign any_valid = |bus.req_valid;
    assign gnt_id    = (&bus.req_valid) ? prio_q : bus.req_valid[1];
    assign req_hs    = (state_q == IDLE) && any_valid;
    assign old_val   = bus.csr_rd_data;

    always_comb begin
        new_val = old_val;
        case (op_q)
            OpWrite: new_val = wdata_q;
            OpSet:   new_val = old_val | wdata_q;
            OpClear: new_val = old_val & ~wdata_q;
            default: new_val = old_val;
        endcase
        wr_val = (new_val & WriteMask) | (old_val & ~WriteMask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = 2'b00;
        bus.csr_wr_en   = 1'b0;
        bus.csr_wr_data = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) bus.req_ready[gnt_id] = 1'b1;
            end
            EXEC: begin
                bus.csr_wr_en   = (op_q != OpRead) && !bus.csr_rd_error;
                bus.csr_wr_data = wr_val;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= (ResetPrio != 0);
            id_q        <= 1'b0;
            op_q        <= OpRead;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            if (req_hs) begin
                id_q    <= gnt_id;
                op_q    <= bus.req_op[gnt_id];
                wdata_q <= bus.req_wdata[gnt_id];
                prio_q  <= ~gnt_id;
            end
            if (state_q == EXEC) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= id_q;
                rsp_rdata_q <= old_val;
                rsp_error_q <= bus.csr_rd_error;
            end else if ((state_q == RESP) && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ibex_csr_rmw_arb.sv
// Directed bench for ibex_csr_rmw_arb: one full-mask instance for the main sequences and a
// half-mask, requester-1-priority instance for write masking.
module tb_ibex_csr_rmw_arb;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    ibex_csr_rmw_arb_if #(.Width(32)) u0 ();
    ibex_csr_rmw_arb_if #(.Width(32)) u1 ();

    ibex_csr_rmw_arb #(.Width(32), .WriteMask(32'hFFFF_FFFF), .ResetPrio(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(u0.slave));
    ibex_csr_rmw_arb #(.Width(32), .WriteMask(32'h0000_FFFF), .ResetPrio(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(u1.slave));

    // CSR storage models with a preload path
    logic [31:0] csr0, csr1, pre_val;
    logic        pre0 = 1'b0, pre1 = 1'b0, err_inject = 1'b0;

    always @(posedge clk) begin
        if (pre0) csr0 <= pre_val;
        else if (u0.csr_wr_en) csr0 <= u0.csr_wr_data;
    end
    always @(posedge clk) begin
        if (pre1) csr1 <= pre_val;
        else if (u1.csr_wr_en) csr1 <= u1.csr_wr_data;
    end

    assign u0.csr_rd_data  = csr0;
    assign u0.csr_rd_error = err_inject;
    assign u1.csr_rd_data  = csr1;
    assign u1.csr_rd_error = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload0(input logic [31:0] v);
        @(negedge clk); pre_val = v; pre0 = 1'b1;
        @(negedge clk); pre0 = 1'b0;
    endtask

    task automatic preload1(input logic [31:0] v);
        @(negedge clk); pre_val = v; pre1 = 1'b1;
        @(negedge clk); pre1 = 1'b0;
    endtask

    task automatic txn(input int r, input logic [1:0] op, input logic [31:0] wd,
                       input logic [31:0] exp_old, input logic exp_err,
                       input logic exp_we, input logic [31:0] exp_wd);
        int n;
        n = 0;
        @(negedge clk);
        u0.req_op[r]    = op;
        u0.req_wdata[r] = wd;
        u0.req_valid[r] = 1'b1;
        #1;
        while (u0.req_ready == 2'b00 && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("grant", 32'(u0.req_ready), (r == 1) ? 32'd2 : 32'd1);
        @(negedge clk);
        u0.req_valid[r] = 1'b0;
        #1;
        check("exec_ready", 32'(u0.req_ready), 32'd0);
        check("wr_en", 32'(u0.csr_wr_en), 32'(exp_we));
        if (exp_we) check("wr_data", u0.csr_wr_data, exp_wd);
        @(negedge clk); #1;
        check("rsp_valid", 32'(u0.rsp_valid), 32'd1);
        check("rsp_id", 32'(u0.rsp_id), 32'(r));
        check("rsp_rdata", u0.rsp_rdata, exp_old);
        check("rsp_error", 32'(u0.rsp_error), 32'(exp_err));
        u0.rsp_ready = 1'b1;
        @(negedge clk);
        u0.rsp_ready = 1'b0;
        #1;
        check("rsp_drop", 32'(u0.rsp_valid), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 32'(u0.req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(u0.rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(u0.rsp_id), 32'd0);
        check({tag, "_rsp_rdata"}, u0.rsp_rdata, 32'd0);
        check({tag, "_rsp_error"}, 32'(u0.rsp_error), 32'd0);
        check({tag, "_wr_en"}, 32'(u0.csr_wr_en), 32'd0);
        check({tag, "_wr_data"}, u0.csr_wr_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] gseq [4];
        logic       rid  [4];
        int         gi, ri;

        u0.req_valid = '0; u0.req_op = '0; u0.req_wdata = '0; u0.rsp_ready = 1'b0;
        u1.req_valid = '0; u1.req_op = '0; u1.req_wdata = '0; u1.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // Single WRITE then READ back
        preload0(32'h0000_0000);
        txn(0, OP_WRITE, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("csr_after_write", csr0, 32'hDEAD_BEEF);
        txn(0, OP_READ, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        check("csr_after_read", csr0, 32'hDEAD_BEEF);

        // SET / CLEAR from requester 1
        preload0(32'h0000_00F0);
        txn(1, OP_SET, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b1, 32'h0000_00FF);
        check("csr_after_set", csr0, 32'h0000_00FF);
        txn(1, OP_CLEAR, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_000F);
        check("csr_after_clear", csr0, 32'h0000_000F);

        // Read-integrity error suppresses the write
        preload0(32'h0000_0055);
        err_inject = 1'b1;
        txn(0, OP_WRITE, 32'h0000_00AA, 32'h0000_0055, 1'b1, 1'b0, 32'h0);
        err_inject = 1'b0;
        check("csr_after_err", csr0, 32'h0000_0055);

        // Backpressure with a second request waiting, then reset while in RESP
        @(negedge clk);
        u0.req_op[0] = OP_WRITE; u0.req_wdata[0] = 32'h77; u0.req_valid[0] = 1'b1;
        #1;
        check("bp_grant", 32'(u0.req_ready), 32'd1);
        @(negedge clk);
        u0.req_valid[0] = 1'b0;
        u0.req_op[1] = OP_WRITE; u0.req_wdata[1] = 32'h99; u0.req_valid[1] = 1'b1;
        #1;
        check("bp_exec_ready", 32'(u0.req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("bp_rsp_valid", 32'(u0.rsp_valid), 32'd1);
            check("bp_rsp_rdata", u0.rsp_rdata, 32'h0000_0055);
            check("bp_rsp_id", 32'(u0.rsp_id), 32'd0);
            check("bp_ready", 32'(u0.req_ready), 32'd0);
        end
        check("bp_csr", csr0, 32'h0000_0077);
        @(negedge clk);
        rst_n = 1'b0;
        u0.req_valid = 2'b00;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("csr_after_reset", csr0, 32'h0000_0077);

        // Round-robin with both requesters continuously valid
        gi = 0; ri = 0;
        @(negedge clk);
        u0.req_op[0] = OP_WRITE; u0.req_wdata[0] = 32'h1;
        u0.req_op[1] = OP_WRITE; u0.req_wdata[1] = 32'h2;
        u0.req_valid = 2'b11;
        u0.rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (u0.req_ready != 2'b00 && gi < 4) begin gseq[gi] = u0.req_ready; gi++; end
            if (u0.rsp_valid && ri < 4) begin rid[ri] = u0.rsp_id; ri++; end
            @(negedge clk);
        end
        u0.req_valid = 2'b00;
        u0.rsp_ready = 1'b0;
        #1;
        check("rr_grants", 32'(gi), 32'd4);
        check("rr_rsps", 32'(ri), 32'd4);
        check("rr_g0", 32'(gseq[0]), 32'd1);
        check("rr_g1", 32'(gseq[1]), 32'd2);
        check("rr_g2", 32'(gseq[2]), 32'd1);
        check("rr_g3", 32'(gseq[3]), 32'd2);
        check("rr_id0", 32'(rid[0]), 32'd0);
        check("rr_id1", 32'(rid[1]), 32'd1);
        check("rr_id2", 32'(rid[2]), 32'd0);
        check("rr_id3", 32'(rid[3]), 32'd1);
        check("rr_csr", csr0, 32'h2);

        // Write mask on the second instance, which starts with priority on requester 1
        preload1(32'h1234_5678);
        @(negedge clk);
        u1.req_op[0] = OP_WRITE; u1.req_wdata[0] = 32'h0;
        u1.req_op[1] = OP_WRITE; u1.req_wdata[1] = 32'hFFFF_FFFF;
        u1.req_valid = 2'b11;
        #1;
        check("mask_grant", 32'(u1.req_ready), 32'd2);
        @(negedge clk);
        u1.req_valid = 2'b00;
        #1;
        check("mask_wr_en", 32'(u1.csr_wr_en), 32'd1);
        check("mask_wr_data", u1.csr_wr_data, 32'h1234_FFFF);
        @(negedge clk); #1;
        check("mask_rsp_valid", 32'(u1.rsp_valid), 32'd1);
        check("mask_rsp_id", 32'(u1.rsp_id), 32'd1);
        check("mask_rsp_rdata", u1.rsp_rdata, 32'h1234_5678);
        u1.rsp_ready = 1'b1;
        @(negedge clk);
        u1.rsp_ready = 1'b0;
        #1;
        check("mask_csr", csr1, 32'h1234_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ibex_csr_rmw_arb.md
Name: ibex_csr_rmw_arb

Overview:
- Two-requester arbiter and read-modify-write sequencer for one CSR storage primitive (Width-bit register with write enable, read data and read-integrity error).
- Shares the register between the core CSR path (requester 0) and the debug/DMA path (requester 1).
- Performs READ/WRITE/SET/CLEAR atomically as one read-then-write sequence.
- Returns the pre-operation value and an error flag per transaction.

Parameters:
- Width, 32, CSR data width in bits.
- WriteMask, all ones ('1), per-bit writability; bits with mask 0 keep their old value on every write.
- ResetPrio, 0, requester that holds priority out of reset (0 or 1).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  2  per-requester request valid
- req_ready_o  output  2  per-requester request accept
- req_op_i  input  2x2  per-requester op: 00 READ, 01 WRITE, 10 SET, 11 CLEAR
- req_wdata_i  input  2xWidth  per-requester operand
- rsp_valid_o  output  1  response valid
- rsp_id_o  output  1  requester the response belongs to
- rsp_rdata_o  output  Width  CSR value before the operation
- rsp_error_o  output  1  CSR read-integrity error seen during the operation
- rsp_ready_i  input  1  response consumer accept
- csr_wr_data_o  output  Width  write data to CSR primitive
- csr_wr_en_o  output  1  write enable to CSR primitive
- csr_rd_data_i  input  Width  CSR primitive read data
- csr_rd_error_i  input  1  CSR primitive shadow-mismatch error

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-low on rst_ni.
- Reset values: state IDLE, priority pointer = ResetPrio, req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_rdata_o=0, rsp_error_o=0, csr_wr_en_o=0, csr_wr_data_o=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE arbitration:
  - If any req_valid_i is set, grant one requester.
  - When both are valid, grant the priority-pointer requester.
  - req_ready_o[grant]=1 combinationally for that cycle only; the other bit stays 0.
  - On the handshake, latch id, op and wdata, then go to EXEC.
  - The priority pointer moves to the non-granted requester (round-robin).
  - A sole valid requester is granted regardless of the pointer; the pointer still flips to the other requester.
- req_ready_o is 0 in EXEC and RESP. At most one transaction is in flight.
- EXEC (exactly 1 cycle):
  - Sample csr_rd_data_i as old and csr_rd_error_i as err.
  - Compute new: WRITE=wdata, SET=old|wdata, CLEAR=old&~wdata, READ=old.
  - Apply the mask: wr = (new & WriteMask) | (old & ~WriteMask).
  - Set csr_wr_en_o=1 iff op!=READ and err==0, with csr_wr_data_o=wr (combinational from csr_rd_data_i). An error suppresses the write.
  - Register old into rsp_rdata_o, err into rsp_error_o, id into rsp_id_o; set rsp_valid_o=1; go to RESP.
- RESP:
  - rsp_valid_o stays 1 and payload stays stable until rsp_ready_i=1.
  - On the handshake, clear rsp_valid_o and return to IDLE.
  - The next grant can occur in the cycle after the response handshake.
  - Minimum throughput is one transaction per 3 cycles.
- csr_wr_en_o is 0 outside EXEC.
- Latency: request handshake at cycle N; CSR written at edge N+2; rsp_valid_o from cycle N+2.
- A new request held valid during EXEC/RESP waits without being acknowledged. req_* inputs may change freely while ready=0.
- Reset asserted mid-transaction returns to reset values immediately, with no partial CSR write after reset. The CSR primitive resets independently.
- The block does not check requester payload stability; the payload is only sampled on the handshake.

Test Plan:
- Single WRITE: CSR=0x0, req0 WRITE 0xDEADBEEF -> ready0 one cycle; csr_wr_en_o=1 for 1 cycle with data 0xDEADBEEF; rsp id=0, rdata=0x0, error=0; next READ returns 0xDEADBEEF.
- SET/CLEAR: CSR=0x000000F0; req1 SET 0x0000000F -> CSR 0x000000FF, rsp rdata 0xF0; then CLEAR 0x000000F0 -> CSR 0x0000000F, rsp rdata 0xFF.
- Round-robin: ResetPrio=0, both valid continuously with WRITE 0x1 and 0x2 -> grant order 0,1,0,1; each response id matches; final CSR matches the last granted write.
- WriteMask=0x0000FFFF: CSR=0x12345678, WRITE 0xFFFFFFFF -> CSR 0x1234FFFF, rdata 0x12345678.
- Error: csr_rd_error_i=1 during EXEC of a WRITE 0xAA -> csr_wr_en_o stays 0, rsp_error_o=1, CSR unchanged.
- Backpressure/reset: hold rsp_ready_i=0 for 5 cycles -> rsp payload stable, req_ready_o=0 throughout; assert rst_ni low in RESP -> all outputs 0 next, state IDLE.
